apb_mst_bridge: RTL
===================

Name: apb_mst_bridge

Overview:
- APB requester: converts a simple valid/ready command stream into APB3/APB4 transfers (PSEL/PENABLE/PSTRB) toward one completer, e.g. the dual-port APB memory.
- Returns read data and error status on a valid/ready response channel.
- Includes an access-phase timeout so a hung completer cannot stall the requester forever.
- Sits between a test/host agent or bus fabric and the APB completer side of apb_if.

Parameters:
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout.
- ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH: taken from apb_pkg, not module parameters.

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  byte strobes (forced 0 on reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_slverr  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_WIDTH
- PWDATA  out  DATA_WIDTH
- PSTRB  out  STRB_WIDTH
- PRDATA  in  DATA_WIDTH
- PREADY, PSLVERR  in  1

Behaviour:
- Reset (PRESETn low at PCLK edge): state IDLE.
  - All outputs 0, except cmd_ready, which is 1 in IDLE.
  - Timeout counter cleared.
  - Reset mid-transfer drops PSEL/PENABLE on that same edge; the in-flight command and any pending response are discarded.
- States (apb_state_t extended): IDLE, SETUP, ACCESS, RESP.
- All APB outputs and rsp_* are registered. cmd_ready = (state==IDLE) || (state==RESP && rsp_ready).
- IDLE:
  - On cmd_valid: capture addr/write/wdata/strb into PADDR/PWRITE/PWDATA/PSTRB; next SETUP.
  - Otherwise stay IDLE.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; next ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA/PSTRB held stable from SETUP until completion.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into rsp_*; rsp_timeout=0; next RESP with PSEL=PENABLE=0.
  - PREADY=0: increment timeout counter. When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), next RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, PSEL=PENABLE=0.
  - PSLVERR and PRDATA are ignored unless PREADY=1.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready.
  - rsp_ready && cmd_valid: accept the new command and go straight to SETUP (no IDLE bubble).
  - rsp_ready only: go to IDLE.
- Latency with a zero-wait completer: command accept at edge N → SETUP N+1 → ACCESS N+2 → rsp_valid N+3. Minimum 3 cycles per transfer.
- PSTRB is forced to 0 on reads (APB4 rule). PADDR/PWDATA keep their last values while idle.
- Timeout counter is cleared on entry to SETUP. Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.

Decomposition:
- apb_pkg gains:
  - RESP state in apb_state_t
  - apb_cmd_t struct (addr, write, wdata, strb)
  - apb_rsp_t struct (rdata, slverr, timeout)
- Top-level variant connects via an apb_if requester modport (mst_mp) alongside the explicit ports.
- One sub-module: apb_timeout_cnt (enable/clear/expired), reusable by other APB agents.

Test Plan:
- Write 0x0000_0012, strb 4'b1111, zero-wait completer → SETUP 1 cycle, ACCESS 1 cycle, rsp_valid 3 cycles after accept, rsp_slverr=0, rsp_rdata=0.
- Read addr 0x012 from a completer inserting 2 wait states, PRDATA=0xDEAD_BEEF → PENABLE high 3 cycles, rsp_rdata=0xDEAD_BEEF, PSTRB=0 throughout.
- Write to addr 0x111 with completer asserting PSLVERR+PREADY → rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=4, PREADY stuck 0 → PSEL drops after 4 ACCESS cycles, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- Back-to-back: cmd_valid held, rsp_ready=1 → RESP→SETUP directly, PSEL low exactly 1 cycle between transfers; rsp_ready=0 for 5 cycles → rsp_* stable, cmd_ready=0.
- PRESETn low during ACCESS → next edge PSEL=PENABLE=rsp_valid=0, state IDLE, the following command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus widths, requester state type and the command /
// response records used by APB agents.
//   ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH : bus geometry
//   apb_state_t : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   apb_cmd_t   : captured command (addr, write, wdata, strb)
//   apb_rsp_t   : completed response (rdata, slverr, timeout)
package apb_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS,
      APB_RESP
   } apb_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  write;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
   } apb_cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  slverr;
      logic                  timeout;
   } apb_rsp_t;

   // Counter width able to hold 0..limit, never narrower than one bit.
   function automatic int cnt_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_mst_bridge_timeout_cnt.sv
// apb_timeout_cnt: wait-state watchdog for APB agents.
//   clk     : clock
//   rst_n   : synchronous active-low reset (clears the count)
//   clr     : synchronous clear, used when a new transfer starts
//   en      : count this cycle (completer is still holding PREADY low)
//   expired : high in the enabled cycle whose increment reaches LIMIT;
//             constantly low when LIMIT is 0 (watchdog disabled)
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = cnt_width(LIMIT);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count_reg <= '0;
      end else if (en && !expired) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Flag the cycle whose increment would make the count equal LIMIT, so
   // the owner can leave ACCESS on that same edge.
   generate
      if (LIMIT > 0) begin : g_limit
         assign expired = en && (count_reg == W'(LIMIT - 1));
      end else begin : g_nolimit
         assign expired = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/apb_mst_bridge.sv
// apb_mst_bridge: APB3/APB4 requester driven by a valid/ready command stream,
// returning read data / error status on a valid/ready response stream.
//   PCLK, PRESETn            : clock, synchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_addr/write/wdata/strb: command fields (strb forced to 0 on reads)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata/slverr/timeout : response fields
//   PSEL..PSTRB              : registered APB requester outputs
//   PRDATA, PREADY, PSLVERR  : APB completer inputs
module apb_mst_bridge
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [STRB_WIDTH-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   apb_state_t state_reg;
   apb_cmd_t   cmd_reg;
   apb_rsp_t   rsp_reg;
   logic       psel_reg;
   logic       penable_reg;
   logic       rsp_valid_reg;

   apb_cmd_t   new_cmd;
   logic       accept;
   logic       access_wait;
   logic       timeout_hit;

   // A response being consumed frees the bridge in the same cycle, which is
   // what lets RESP hand over directly to the next SETUP.
   assign cmd_ready   = (state_reg == APB_IDLE) ||
                        ((state_reg == APB_RESP) && rsp_ready);
   assign accept      = cmd_valid && cmd_ready;
   assign access_wait = (state_reg == APB_ACCESS) && !PREADY;

   // Reads never drive byte strobes.
   assign new_cmd = '{addr:  cmd_addr,
                      write: cmd_write,
                      wdata: cmd_wdata,
                      strb:  cmd_write ? cmd_strb : '0};

   apb_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .clr     (accept),
      .en      (access_wait),
      .expired (timeout_hit)
   );

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_reg     <= APB_IDLE;
         cmd_reg       <= '0;
         rsp_reg       <= '0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         rsp_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            APB_IDLE: begin
               if (cmd_valid) begin
                  cmd_reg   <= new_cmd;
                  psel_reg  <= 1'b1;
                  state_reg <= APB_SETUP;
               end
            end
            APB_SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= APB_ACCESS;
            end
            APB_ACCESS: begin
               if (PREADY) begin
                  rsp_reg       <= '{rdata:   cmd_reg.write ? '0 : PRDATA,
                                     slverr:  PSLVERR,
                                     timeout: 1'b0};
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= APB_RESP;
               end else if (timeout_hit) begin
                  rsp_reg       <= '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
                  psel_reg      <= 1'b0;
                  penable_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= APB_RESP;
               end
            end
            APB_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  if (cmd_valid) begin
                     cmd_reg   <= new_cmd;
                     psel_reg  <= 1'b1;
                     state_reg <= APB_SETUP;
                  end else begin
                     state_reg <= APB_IDLE;
                  end
               end
            end
            default: state_reg <= APB_IDLE;
         endcase
      end
   end

   assign PSEL        = psel_reg;
   assign PENABLE     = penable_reg;
   assign PWRITE      = cmd_reg.write;
   assign PADDR       = cmd_reg.addr;
   assign PWDATA      = cmd_reg.wdata;
   assign PSTRB       = cmd_reg.strb;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rsp_reg.rdata;
   assign rsp_slverr  = rsp_reg.slverr;
   assign rsp_timeout = rsp_reg.timeout;

endmodule
